dmac_channel_scheduler: RTL and testbench

- Sequences the DMA controller's channels onto the single shared AHB master datapath.
- Arbitrates among channel requests using fixed or round-robin priority, then runs the Bus_Req/Bus_Grant handshake with the system bus arbiter.
- Drives exactly one channel enable to the datapath and holds the datapath while bus ownership is lost.
- Sits between the channel request pins and the datapath, replacing ad-hoc channel selection in the main controller.

---
 rtl/dmac_sched_pkg.sv | 16 +
 rtl/dmac_rr_picker.sv | 50 +++++
 rtl/dmac_channel_scheduler.sv | 162 ++++++++++++++++
 tb/tb_dmac_channel_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmac_sched_pkg.sv
// rtl/dmac_sched_pkg.sv - shared types and defaults for the DMA channel scheduler
// Purpose: scheduler state encoding and default channel count / grant timeout.
package dmac_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUS_REQ = 3'd1,
        ACTIVE  = 3'd2,
        PAUSE   = 3'd3,
        DONE    = 3'd4
    } sched_state_t;

    localparam int DEF_NUM_CH  = 2;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/dmac_rr_picker.sv
// rtl/dmac_rr_picker.sv - combinational fixed / round-robin winner picker
// Purpose: choose one set bit of elig.
//   Fixed mode picks the lowest index.
//   Round-robin mode picks the first set bit above last, wrapping to the lowest.
// Ports:
//   elig    in  NUM_CH  candidate vector
//   last    in  CH_W    index served most recently (round-robin reference)
//   rr_mode in  1       0 = fixed priority, 1 = round-robin
//   winner  out CH_W    selected index (0 when valid is low)
//   valid   out 1       elig has at least one bit set
module dmac_rr_picker
    import dmac_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig,
    input  logic [CH_W-1:0]   last,
    input  logic              rr_mode,
    output logic [CH_W-1:0]   winner,
    output logic              valid
);

    logic            lo_found;
    logic            hi_found;
    logic [CH_W-1:0] lo_idx;
    logic [CH_W-1:0] hi_idx;

    // The wrapped round-robin search is split into two scans: the first set
    // bit strictly above last, else the lowest set bit overall (the wrap).
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (elig[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = CH_W'(i);
            end
            if (elig[i] && !hi_found && (i > int'(last))) begin
                hi_found = 1'b1;
                hi_idx   = CH_W'(i);
            end
        end
        valid  = lo_found;
        winner = (rr_mode && hi_found) ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/dmac_channel_scheduler.sv
// rtl/dmac_channel_scheduler.sv - DMA channel arbitration and AHB bus ownership sequencing
// Purpose: pick one eligible channel, win the system bus, and enable that channel on
//   the shared datapath. The datapath is frozen while the grant is lost.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   dma_req, ch_cfg_valid  per-channel request and programmed/enabled flags
//   rr_mode             0 = fixed priority, 1 = round-robin
//   bus_grant           grant from the system arbiter
//   ch_done, ch_error   completion pulses from the datapath
//   bus_req             request to the system arbiter
//   ch_en               one-hot channel enable to the datapath
//   hold                datapath freeze while bus ownership is lost
//   req_ack             one-cycle acknowledge to the served peripheral
//   active_ch           latched channel index
//   busy                scheduler not idle
//   err_pulse           one-cycle pulse when a transfer completes with an error
//   timeout_pulse       one-cycle pulse when the grant wait backs off
module dmac_channel_scheduler
    import dmac_sched_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] dma_req,
    input  logic [NUM_CH-1:0] ch_cfg_valid,
    input  logic              rr_mode,
    input  logic              bus_grant,
    input  logic              ch_done,
    input  logic              ch_error,
    output logic              bus_req,
    output logic [NUM_CH-1:0] ch_en,
    output logic              hold,
    output logic [NUM_CH-1:0] req_ack,
    output logic [CH_W-1:0]   active_ch,
    output logic              busy,
    output logic              err_pulse,
    output logic              timeout_pulse
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  active_ch_q, active_ch_d;
    logic [CH_W-1:0]  last_q, last_d;
    logic             err_q, err_d;

    logic [NUM_CH-1:0] elig;
    logic [CH_W-1:0]   pick_win;
    logic              pick_valid;
    logic              en_any;
    logic              ack_any;

    assign elig = dma_req & ch_cfg_valid;

    dmac_rr_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .elig    (elig),
        .last    (last_q),
        .rr_mode (rr_mode),
        .winner  (pick_win),
        .valid   (pick_valid)
    );

    // Pointer resets to the top index so channel 0 is first in round-robin.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            active_ch_q <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_ch_q <= active_ch_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        active_ch_d   = active_ch_q;
        last_d        = last_q;
        err_d         = err_q;
        bus_req       = 1'b0;
        hold          = 1'b0;
        en_any        = 1'b0;
        ack_any       = 1'b0;
        err_pulse     = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    active_ch_d = pick_win;
                    state_d     = BUS_REQ;
                end
            end
            BUS_REQ: begin
                // Completion pulses are meaningless before the datapath owns the bus.
                bus_req = 1'b1;
                if (bus_grant) begin
                    state_d = ACTIVE;
                end else if (cnt_q == CNT_LAST) begin
                    // Back off without touching the pointer; the channel re-competes.
                    timeout_pulse = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                bus_req = 1'b1;
                en_any  = 1'b1;
                // A completion wins over a grant drop in the same cycle.
                if (ch_done || ch_error) begin
                    err_d   = ch_error;
                    state_d = DONE;
                end else if (!bus_grant) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                bus_req = 1'b1;
                en_any  = 1'b1;
                hold    = 1'b1;
                if (ch_done || ch_error) begin
                    err_d   = ch_error;
                    state_d = DONE;
                end else if (bus_grant) begin
                    state_d = ACTIVE;
                end
            end
            DONE: begin
                ack_any   = 1'b1;
                err_pulse = err_q;
                last_d    = active_ch_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ch_en   = en_any  ? (NUM_CH'(1) << active_ch_q) : '0;
        req_ack = ack_any ? (NUM_CH'(1) << active_ch_q) : '0;
    end

    assign active_ch = active_ch_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmac_channel_scheduler.sv
// tb/tb_dmac_channel_scheduler.sv - self-checking bench for dmac_channel_scheduler
module tb_dmac_channel_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dma_req;
    logic [3:0] ch_cfg_valid;
    logic       rr_mode;
    logic       bus_grant;
    logic       ch_done;
    logic       ch_error;
    logic       bus_req;
    logic [3:0] ch_en;
    logic       hold;
    logic [3:0] req_ack;
    logic [1:0] active_ch;
    logic       busy;
    logic       err_pulse;
    logic       timeout_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmac_channel_scheduler #(
        .NUM_CH  (4),
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dma_req       (dma_req),
        .ch_cfg_valid  (ch_cfg_valid),
        .rr_mode       (rr_mode),
        .bus_grant     (bus_grant),
        .ch_done       (ch_done),
        .ch_error      (ch_error),
        .bus_req       (bus_req),
        .ch_en         (ch_en),
        .hold          (hold),
        .req_ack       (req_ack),
        .active_ch     (active_ch),
        .busy          (busy),
        .err_pulse     (err_pulse),
        .timeout_pulse (timeout_pulse)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  cfg;
        logic        rr;
        logic        grant;
        logic        done;
        logic        err;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [14:0] o(input logic br, input logic [3:0] en, input logic hd,
                                      input logic [3:0] ak, input logic [1:0] ac,
                                      input logic bz, input logic ep, input logic tp);
        return {br, en, hd, ak, ac, bz, ep, tp};
    endfunction

    function automatic logic [14:0] outs();
        return {bus_req, ch_en, hold, req_ack, active_ch, busy, err_pulse, timeout_pulse};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (ch_en == 4'b0 && n < 20) begin
            cyc();
            n++;
        end
        chk(name, (n < 20) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        // rows: inputs of the cycle, outputs expected during that same cycle
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 4'h0, 0, 4'h0, 2'd0, 0, 0, 0)};
        tbl[1]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 4'h0, 0, 4'h0, 2'd0, 0, 0, 0)};
        tbl[2]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, o(1, 4'h0, 0, 4'h0, 2'd0, 1, 0, 0)};
        tbl[3]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, o(1, 4'h0, 0, 4'h0, 2'd0, 1, 0, 0)};
        tbl[4]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, o(1, 4'h0, 0, 4'h0, 2'd0, 1, 0, 0)};
        tbl[5]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, o(1, 4'h1, 0, 4'h0, 2'd0, 1, 0, 0)};
        tbl[6]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, o(1, 4'h1, 0, 4'h0, 2'd0, 1, 0, 0)};
        tbl[7]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, o(1, 4'h1, 0, 4'h0, 2'd0, 1, 0, 0)};
        tbl[8]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, o(1, 4'h1, 0, 4'h0, 2'd0, 1, 0, 0)};
        tbl[9]  = '{1'b1, 4'h3, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, o(1, 4'h1, 0, 4'h0, 2'd0, 1, 0, 0)};
        tbl[10] = '{1'b1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 4'h0, 0, 4'h1, 2'd0, 1, 0, 0)};
        tbl[11] = '{1'b1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 4'h0, 0, 4'h0, 2'd0, 0, 0, 0)};
        tbl[12] = '{1'b1, 4'h2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, o(1, 4'h0, 0, 4'h0, 2'd1, 1, 0, 0)};
        tbl[13] = '{1'b1, 4'h2, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, o(1, 4'h2, 0, 4'h0, 2'd1, 1, 0, 0)};
        tbl[14] = '{1'b1, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 4'h0, 0, 4'h2, 2'd1, 1, 0, 0)};
        tbl[15] = '{1'b1, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 4'h0, 0, 4'h0, 2'd1, 0, 0, 0)};
        tbl[16] = '{1'b1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 4'h0, 0, 4'h0, 2'd1, 0, 0, 0)};
        tbl[17] = '{1'b1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 4'h0, 0, 4'h0, 2'd1, 0, 0, 0)};

        rst = 1'b0; dma_req = '0; ch_cfg_valid = '0; rr_mode = 1'b0;
        bus_grant = 1'b0; ch_done = 1'b0; ch_error = 1'b0;
        cyc();
        cyc();

        // fixed priority, BUS_REQ ignoring completions, cfg masking
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; dma_req = tbl[i].req; ch_cfg_valid = tbl[i].cfg;
            rr_mode = tbl[i].rr; bus_grant = tbl[i].grant;
            ch_done = tbl[i].done; ch_error = tbl[i].err;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // round-robin fairness with all channels requesting
        rst = 1'b0; ch_done = 1'b0; ch_error = 1'b0;
        cyc();
        cyc();
        rst = 1'b1; rr_mode = 1'b1; ch_cfg_valid = 4'hF; dma_req = 4'hF; bus_grant = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_en("rr_wait");
            chk($sformatf("rr_ch%0d", k), 32'(active_ch), 32'(k % 4));
            chk($sformatf("rr_en%0d", k), 32'(ch_en), 32'(1 << (k % 4)));
            ch_done = 1'b1;
            cyc();
            ch_done = 1'b0;
            chk($sformatf("rr_ack%0d", k), 32'(req_ack), 32'(1 << (k % 4)));
        end

        // grant loss for three cycles while active on channel 2
        rr_mode = 1'b0; dma_req = 4'h4;
        wait_en("gl_wait");
        chk("gl_en", 32'(ch_en), 32'h4);
        bus_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("gl_hold%0d", k), 32'({bus_req, ch_en, hold}), 32'({1'b1, 4'h4, 1'b1}));
        end
        bus_grant = 1'b1;
        cyc();
        chk("gl_resume", 32'({bus_req, ch_en, hold}), 32'({1'b1, 4'h4, 1'b0}));
        ch_done = 1'b1;
        cyc();
        ch_done = 1'b0;
        chk("gl_ack", 32'({req_ack, err_pulse}), 32'({4'h4, 1'b0}));

        // grant never arrives: back off on the eighth BUS_REQ cycle
        dma_req = 4'h0; bus_grant = 1'b0;
        cyc();
        chk("to_idle", 32'(busy), 32'd0);
        dma_req = 4'h1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("to_c%0d", k), 32'({bus_req, timeout_pulse, req_ack}),
                32'({1'b1, (k == 8), 4'h0}));
        end
        cyc();
        chk("to_drop", 32'({bus_req, busy, timeout_pulse, req_ack}), 32'd0);
        cyc();
        chk("to_rereq", 32'({bus_req, active_ch}), 32'({1'b1, 2'd0}));

        // error together with grant drop goes to DONE, not PAUSE
        bus_grant = 1'b1;
        cyc();
        chk("er_active", 32'(ch_en), 32'h1);
        ch_error = 1'b1; bus_grant = 1'b0;
        cyc();
        ch_error = 1'b0;
        chk("er_done", 32'({err_pulse, req_ack, hold, bus_req, ch_en}), 32'({1'b1, 4'h1, 1'b0, 1'b0, 4'h0}));
        cyc();
        chk("er_after", 32'({err_pulse, req_ack}), 32'd0);

        // reset mid-transfer, then channel 0 first in round-robin
        rr_mode = 1'b1; dma_req = 4'h4; bus_grant = 1'b1;
        wait_en("rs_wait");
        chk("rs_ch", 32'(active_ch), 32'd2);
        rst = 1'b0;
        cyc();
        chk("rs_outs", 32'(outs()), 32'd0);
        rst = 1'b1; dma_req = 4'hF;
        wait_en("rs_wait2");
        chk("rs_first", 32'(active_ch), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
